// File: rtl/qsys_block_key_if.sv
// Avalon-MM slave bus bundle for the push-button key block: address/strobe/data
// from the master, registered read data and level interrupt back from the slave.
interface qsys_block_key_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/qsys_block_key.sv
// Four debounced active-low push buttons behind an Avalon-MM register file with
// DATA, IRQMASK and press-edge capture (EDGECAP) registers plus a level interrupt.
module qsys_block_key #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [3:0]         in_port,
    qsys_block_key_if.slave    bus
);

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [3:0]  sync_1;
    logic [3:0]  sync_2;
    logic [3:0]  debounced;
    logic [3:0]  debounced_next;
    logic [15:0] count      [4];
    logic [15:0] count_next [4];
    logic [3:0]  irq_mask;
    logic [3:0]  irq_mask_next;
    logic [3:0]  edge_cap;
    logic [3:0]  edge_cap_next;
    logic [3:0]  press;
    logic [3:0]  cap_clear;
    logic [3:0]  read_value;
    logic        bus_write;
    logic        unused_writedata;

    assign unused_writedata = ^bus.writedata[31:4];
    assign bus_write        = bus.chipselect & ~bus.write_n;

    // A bit only flips after its synchronized value has disagreed for DEBOUNCE_CYCLES edges
    always_comb begin
        debounced_next = debounced;
        for (int i = 0; i < 4; i++) begin
            count_next[i] = count[i];
            if (sync_2[i] == debounced[i]) begin
                count_next[i] = '0;
            end else if (count[i] == CNT_LAST) begin
                debounced_next[i] = sync_2[i];
                count_next[i]     = '0;
            end else begin
                count_next[i] = count[i] + 16'd1;
            end
        end
    end

    assign press = debounced & ~debounced_next;

    always_comb begin
        irq_mask_next = irq_mask;
        cap_clear     = '0;
        if (bus_write && bus.address == 2'd2) begin
            irq_mask_next = bus.writedata[3:0];
        end
        if (bus_write && bus.address == 2'd3) begin
            cap_clear = bus.writedata[3:0];
        end
        // Capture is OR-ed in after the clear so a coincident press is never lost
        edge_cap_next = (edge_cap & ~cap_clear) | press;
    end

    always_comb begin
        read_value = '0;
        case (bus.address)
            2'd0:    read_value = debounced;
            2'd2:    read_value = irq_mask;
            2'd3:    read_value = edge_cap;
            default: read_value = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1       <= 4'hF;
            sync_2       <= 4'hF;
            debounced    <= 4'hF;
            for (int i = 0; i < 4; i++) begin
                count[i] <= '0;
            end
            irq_mask     <= '0;
            edge_cap     <= '0;
            bus.readdata <= '0;
            bus.irq      <= 1'b0;
        end else begin
            sync_1       <= in_port;
            sync_2       <= sync_1;
            debounced    <= debounced_next;
            for (int i = 0; i < 4; i++) begin
                count[i] <= count_next[i];
            end
            irq_mask     <= irq_mask_next;
            edge_cap     <= edge_cap_next;
            bus.readdata <= {28'd0, read_value};
            bus.irq      <= |(edge_cap & irq_mask);
        end
    end

endmodule

// File: doc/qsys_block_key.md
QSYS_BLOCK_KEY -- requirements
Module: qsys_block_key

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning the stable-input cycles required before the debounced value changes (range 2..65535).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port address, input, 2 bits: Avalon-MM word address.
REQ-005 The block SHALL have port chipselect, input, 1 bit: Avalon-MM select.
REQ-006 The block SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-007 The block SHALL have port writedata, input, 32 bits: write data.
REQ-008 The block SHALL have port in_port, input, 4 bits: asynchronous active-low push-button inputs.
REQ-009 The block SHALL have port readdata, output, 32 bits: registered read data, bits 31:4 always 0.
REQ-010 The block SHALL have port irq, output, 1 bit: active-high level interrupt.

Function
REQ-011 Each in_port bit SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-012 Each bit SHALL have an independent 16-bit debounce counter:
- Synchronized bit equals the debounced bit: counter clears to 0.
- Otherwise: counter increments.
- Counter reaches DEBOUNCE_CYCLES-1 while still differing: the debounced bit takes the synchronized value on that edge and the counter clears.
REQ-013 The total in_port-to-debounced latency for a clean step SHALL be exactly DEBOUNCE_CYCLES+2 clocks; any glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no change.
REQ-014 The register map SHALL be:
- address 0 = DATA (read-only, debounced value)
- address 1 = reserved (reads 0, writes ignored)
- address 2 = IRQMASK (read/write, 4 bits)
- address 3 = EDGECAP (read, write-1-to-clear, 4 bits)
REQ-015 A write SHALL occur when chipselect=1 and write_n=0; it uses writedata[3:0] only, and writes to address 0 or 1 have no effect.
REQ-016 EDGECAP bit n SHALL set on the clock where debounced bit n transitions 1->0 (press), and hold until cleared.
REQ-017 A write to EDGECAP SHALL clear each bit whose writedata bit is 1 and leave other bits unchanged.
REQ-018 If a set and a clear of the same EDGECAP bit coincide in one cycle, the set SHALL win (bit reads 1 afterwards).
REQ-019 The 0->1 (release) transition SHALL NOT set EDGECAP.
REQ-020 readdata SHALL be registered every clock from the address-selected register, giving read latency 1 with no wait states; chipselect is not required for the read mux.
REQ-021 irq SHALL be registered and equal the OR over n of (EDGECAP[n] AND IRQMASK[n]) as of the previous cycle, i.e. irq follows register state with 1-cycle latency.
REQ-022 Reading any register SHALL have no side effects.

Reset
REQ-023 While reset_n=0, regardless of clk:
- synchronizer flops and debounced value = 4'hF (released)
- debounce counters = 0
- IRQMASK = 0, EDGECAP = 0
- readdata = 0, irq = 0
REQ-024 After reset deassertion with in_port held 4'hF, no EDGECAP bit SHALL set.
REQ-025 Reset asserted mid-debounce SHALL discard the count and any pending transition, with no edge captured.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Scenario 1: reset, in_port=4'hF, read address 0 -> readdata=32'h0000000F one cycle later; irq=0.
REQ-027 Scenario 2: in_port[0] 1->0 held -> DATA reads 4'hE exactly 6 clocks after the change; EDGECAP reads 4'h1.
REQ-028 Scenario 3: in_port[1] low pulse of 3 cycles -> DATA stays 4'hF and EDGECAP stays 0.
REQ-029 Scenario 4: write IRQMASK=4'h1, then press bit 0 -> irq=1 one cycle after EDGECAP sets; write EDGECAP=4'h1 -> EDGECAP=0 and irq=0 one cycle later.
REQ-030 Scenario 5: a write of 4'h4 to EDGECAP in the same cycle bit 2's debounced press lands -> EDGECAP[2]=1.
REQ-031 Scenario 6: reset_n pulsed low mid-debounce of bit 3, then held high with in_port[3]=0 -> DATA[3] goes 0 only after a full fresh DEBOUNCE_CYCLES, EDGECAP[3] sets once, and all registers read 0 during reset.
